pipe_hazard_ctrl: RTL and testbench

// Central hazard/sequencing controller for the 5-stage pipeline (IF, OF, ALU, MA, RW).

---
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stalls, flushes, bubbles and mul/div occupancy.
// Optional PIPE_HAZARD_PERF_EN adds free-running stallCount/flushCount performance counters.
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1_OF,
  input  logic [4:0] rs2_OF,
  input  logic       useRs1_OF,
  input  logic       useRs2_OF,
  input  logic [4:0] rd_ALU,
  input  logic       isWb_ALU,
  input  logic       isLd_ALU,
  input  logic       isMd_ALU,
  input  logic       isBranchTaken_ALU,
  input  logic       extStall,
  output logic       stall_IF,
  output logic       stall_OF,
  output logic       stall_ALU,
  output logic       flush_OF,
  output logic       bubble_ALU,
  output logic       bubble_MA,
  output logic       busyMd
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] stallCount,
  output logic [31:0] flushCount
`endif
);

  typedef enum logic {RUN, MDBUSY} state_t;

  localparam logic [3:0] MD_RELOAD = 4'(MD_LAT - 2);

  state_t     state;
  logic [3:0] mdCnt;
  logic       loadUse;
  logic       branchFlush;

  assign loadUse = isLd_ALU & isWb_ALU &
                   ((useRs1_OF & (rs1_OF == rd_ALU)) | (useRs2_OF & (rs2_OF == rd_ALU)));

  assign branchFlush = !reset && !extStall && (state == RUN) && isBranchTaken_ALU;

  always_comb begin
    stall_IF   = 1'b0;
    stall_OF   = 1'b0;
    stall_ALU  = 1'b0;
    flush_OF   = 1'b0;
    bubble_ALU = 1'b0;
    bubble_MA  = 1'b0;
    busyMd     = 1'b0;
    if (reset) begin
      flush_OF   = 1'b1;
      bubble_ALU = 1'b1;
      bubble_MA  = 1'b1;
    end else if (extStall) begin
      // A frozen mul/div sequence is still in progress, so busyMd stays visible.
      stall_IF  = 1'b1;
      stall_OF  = 1'b1;
      stall_ALU = 1'b1;
      busyMd    = (state == MDBUSY);
    end else if (state == MDBUSY) begin
      busyMd = 1'b1;
      if (mdCnt != 4'd0) begin
        stall_IF  = 1'b1;
        stall_OF  = 1'b1;
        stall_ALU = 1'b1;
        bubble_MA = 1'b1;
      end
    end else if (isBranchTaken_ALU) begin
      flush_OF   = 1'b1;
      bubble_ALU = 1'b1;
    end else if (isMd_ALU) begin
      stall_IF  = 1'b1;
      stall_OF  = 1'b1;
      stall_ALU = 1'b1;
      bubble_MA = 1'b1;
      busyMd    = 1'b1;
    end else if (loadUse) begin
      stall_IF   = 1'b1;
      stall_OF   = 1'b1;
      bubble_ALU = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      mdCnt <= 4'd0;
    end else if (!extStall) begin
      case (state)
        RUN: begin
          if (!isBranchTaken_ALU && isMd_ALU) begin
            state <= MDBUSY;
            mdCnt <= MD_RELOAD;
          end
        end
        MDBUSY: begin
          if (mdCnt != 4'd0) mdCnt <= mdCnt - 4'd1;
          else               state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  // Counters wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCount <= 32'd0;
      flushCount <= 32'd0;
    end else begin
      if (stall_IF || stall_OF || stall_ALU) stallCount <= stallCount + 32'd1;
      if (branchFlush)                       flushCount <= flushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with a queue scoreboard of expected control vectors.
// Expected vector bit order: {stall_IF, stall_OF, stall_ALU, flush_OF, bubble_ALU, bubble_MA, busyMd}.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_OF, rs2_OF, rd_ALU;
  logic       useRs1_OF, useRs2_OF, isWb_ALU, isLd_ALU, isMd_ALU, isBranchTaken_ALU, extStall;
  logic       stall_IF, stall_OF, stall_ALU, flush_OF, bubble_ALU, bubble_MA, busyMd;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stallCount, flushCount;
  int          tbStalls = 0;
  int          tbFlushes = 0;
`endif

  localparam logic [6:0] NONE = 7'b000_000_0;
  localparam logic [6:0] RST  = 7'b000_111_0;
  localparam logic [6:0] LU   = 7'b110_010_0;
  localparam logic [6:0] BR   = 7'b000_110_0;
  localparam logic [6:0] MD   = 7'b111_001_1;
  localparam logic [6:0] REL  = 7'b000_000_1;
  localparam logic [6:0] EXT  = 7'b111_000_0;
  localparam logic [6:0] EXTB = 7'b111_000_1;

  int         testsRun = 0;
  int         testsFailed = 0;
  logic [6:0] expQ[$];
  string      tagQ[$];

  pipe_hazard_ctrl #(.MD_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .rs1_OF(rs1_OF), .rs2_OF(rs2_OF), .useRs1_OF(useRs1_OF), .useRs2_OF(useRs2_OF),
    .rd_ALU(rd_ALU), .isWb_ALU(isWb_ALU), .isLd_ALU(isLd_ALU), .isMd_ALU(isMd_ALU),
    .isBranchTaken_ALU(isBranchTaken_ALU), .extStall(extStall),
    .stall_IF(stall_IF), .stall_OF(stall_OF), .stall_ALU(stall_ALU),
    .flush_OF(flush_OF), .bubble_ALU(bubble_ALU), .bubble_MA(bubble_MA), .busyMd(busyMd)
`ifdef PIPE_HAZARD_PERF_EN
    , .stallCount(stallCount), .flushCount(flushCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput();
    logic [6:0] expected;
    logic [6:0] observed;
    string      tag;
    expected = expQ.pop_front();
    tag      = tagQ.pop_front();
    observed = {stall_IF, stall_OF, stall_ALU, flush_OF, bubble_ALU, bubble_MA, busyMd};
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // One pipeline cycle: inputs already set, expectation queued, sampled mid-cycle.
  task automatic applyStimulus(input logic [6:0] expected, input string tag);
    expQ.push_back(expected);
    tagQ.push_back(tag);
    @(negedge clk);
    checkOutput();
`ifdef PIPE_HAZARD_PERF_EN
    if (reset) begin
      tbStalls  = 0;
      tbFlushes = 0;
    end else begin
      if (expected[6:4] != 3'b000) tbStalls++;
      if (expected == BR)          tbFlushes++;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    reset = 1'b0; extStall = 1'b0;
    rs1_OF = 5'd1; rs2_OF = 5'd2; rd_ALU = 5'd3;
    useRs1_OF = 1'b0; useRs2_OF = 1'b0;
    isWb_ALU = 1'b0; isLd_ALU = 1'b0; isMd_ALU = 1'b0; isBranchTaken_ALU = 1'b0;
  endtask

  task automatic setLoadUseRs2();
    isLd_ALU = 1'b1; isWb_ALU = 1'b1; rd_ALU = 5'd5; rs2_OF = 5'd5; useRs2_OF = 1'b1;
  endtask

  initial begin
    idleInputs();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(RST, "reset");
    reset = 1'b0;
    applyStimulus(NONE, "idle_after_reset");

    setLoadUseRs2();
    applyStimulus(LU, "loaduse_rs2");
    idleInputs();
    applyStimulus(NONE, "loaduse_released");
    isLd_ALU = 1'b1; isWb_ALU = 1'b1; rd_ALU = 5'd9; rs1_OF = 5'd9; useRs1_OF = 1'b1;
    applyStimulus(LU, "loaduse_rs1");
    idleInputs();
    isLd_ALU = 1'b1; isWb_ALU = 1'b1; rd_ALU = 5'd0; rs1_OF = 5'd0; useRs1_OF = 1'b1;
    applyStimulus(LU, "loaduse_r0");
    idleInputs();
    setLoadUseRs2(); isWb_ALU = 1'b0;
    applyStimulus(NONE, "load_no_wb");
    setLoadUseRs2(); useRs2_OF = 1'b0;
    applyStimulus(NONE, "loaduse_rs2_unused");
    setLoadUseRs2(); rd_ALU = 5'd6;
    applyStimulus(NONE, "loaduse_rd_differs");
    setLoadUseRs2(); isBranchTaken_ALU = 1'b1;
    applyStimulus(BR, "branch_over_loaduse");
    idleInputs();
    isBranchTaken_ALU = 1'b1; isMd_ALU = 1'b1;
    applyStimulus(BR, "branch_over_md");
    idleInputs();
    applyStimulus(NONE, "no_md_after_branch");

    // MD_LAT=4: three stall cycles then a release cycle.
    isMd_ALU = 1'b1;
    applyStimulus(MD, "md_entry");
    applyStimulus(MD, "md_busy_2");
    applyStimulus(MD, "md_busy_3");
    applyStimulus(REL, "md_release");
    idleInputs();
    applyStimulus(NONE, "md_done");

    isMd_ALU = 1'b1;
    applyStimulus(MD, "md2_entry");
    extStall = 1'b1;
    applyStimulus(EXTB, "md2_ext_1");
    applyStimulus(EXTB, "md2_ext_2");
    extStall = 1'b0;
    setLoadUseRs2();
    applyStimulus(MD, "md2_busy_ignores_loaduse");
    applyStimulus(MD, "md2_busy_last");
    applyStimulus(REL, "md2_release_delayed");
    idleInputs();
    applyStimulus(NONE, "md2_done");

    isMd_ALU = 1'b1;
    applyStimulus(MD, "md3_entry");
    applyStimulus(MD, "md3_busy");
    reset = 1'b1;
    applyStimulus(RST, "md3_reset");
    idleInputs();
    applyStimulus(NONE, "md3_run_after_reset");
    setLoadUseRs2();
    applyStimulus(LU, "loaduse_after_abort");

    idleInputs();
    extStall = 1'b1; isBranchTaken_ALU = 1'b1;
    applyStimulus(EXT, "ext_over_branch");
    extStall = 1'b0;
    applyStimulus(BR, "branch_1");
    idleInputs();
    applyStimulus(NONE, "gap_1");
    isBranchTaken_ALU = 1'b1;
    applyStimulus(BR, "branch_2");
    idleInputs();
    applyStimulus(NONE, "gap_2");
    isBranchTaken_ALU = 1'b1;
    applyStimulus(BR, "branch_3");
    idleInputs();
    applyStimulus(NONE, "final_idle");

`ifdef PIPE_HAZARD_PERF_EN
    testsRun++;
    assert (flushCount === 32'(tbFlushes)) else begin
      testsFailed++;
      $error("[TB] FAIL flushCount observed=%0d expected=%0d", flushCount, tbFlushes);
    end
    testsRun++;
    assert (stallCount === 32'(tbStalls)) else begin
      testsFailed++;
      $error("[TB] FAIL stallCount observed=%0d expected=%0d", stallCount, tbStalls);
    end
`endif

    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
